// File: rtl/cp0_int_ctrl_if.sv
// System-bridge register port of the CP0 interrupt controller.
interface cp0_int_ctrl_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, we, wdata, input rdata);
  modport slave  (input addr, we, wdata, output rdata);
endinterface

// File: rtl/cp0_int_ctrl.sv
// Interrupt controller feeding CP0 HWInt: sync, edge/level pending, mask,
// fixed priority with nesting, ack/EOI in-service tracking.
module cp0_int_ctrl #(
  parameter int N_SRC       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq_raw,
  input  logic              int_ack,
  cp0_int_ctrl_if.slave     bus,
  output logic [5:0]        hw_int,
  output logic              busy
);
  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;

  state_t state, state_n;
  logic [SYNC_STAGES:0][N_SRC-1:0] sync_q;
  logic [N_SRC-1:0] synced, prev, rise;
  logic [N_SRC-1:0] pending, mask, mode, insv, hw_q;
  logic [N_SRC-1:0] pend_n, insv_n, insv_ack, clr, hw_n;
  logic [N_SRC-1:0] cand, lowest, elig, sel;
  logic             ack_take, eoi, w1c;

  // Last stage of sync_q is the "previous" flop used for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= irq_raw;
      for (int s = 1; s <= SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign synced   = sync_q[SYNC_STAGES-1];
  assign prev     = sync_q[SYNC_STAGES];
  assign rise     = synced & ~prev;
  assign ack_take = int_ack & (|hw_q);
  assign eoi      = bus.we && (bus.addr == 2'd3);
  assign w1c      = bus.we && (bus.addr == 2'd0);

  // Edge bits: set wins over W1C/ack clear. Level bits track the synced line.
  assign clr    = (w1c ? bus.wdata[N_SRC-1:0] : '0) | (ack_take ? hw_q : '0);
  assign pend_n = (mode & (rise | (pending & ~clr))) | (~mode & synced);

  // Ack lands first, then EOI retires the lowest set bit of the result.
  assign insv_ack = insv | (ack_take ? hw_q : '0);
  assign insv_n   = eoi ? (insv_ack & (insv_ack - ONE)) : insv_ack;

  // Only sources strictly above the current service level may nest.
  assign cand   = pending & mask & ~insv;
  assign lowest = insv & (~insv + ONE);
  assign elig   = cand & (lowest - ONE);
  assign sel    = elig & (~elig + ONE);

  always_comb begin
    state_n = state;
    hw_n    = hw_q;
    case (state)
      IDLE: begin
        hw_n = sel;
        if (|sel) state_n = PRESENT;
      end
      PRESENT: begin
        if (ack_take) begin
          hw_n    = '0;
          state_n = SERVICE;
        end else begin
          hw_n = sel;
          if (sel == '0) state_n = (insv_n == '0) ? IDLE : SERVICE;
        end
      end
      SERVICE: begin
        hw_n = sel;
        if (|sel)                state_n = PRESENT;
        else if (insv_n == '0)   state_n = IDLE;
      end
      default: begin
        hw_n    = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
      insv    <= '0;
      hw_q    <= '0;
    end else begin
      state   <= state_n;
      pending <= pend_n;
      insv    <= insv_n;
      hw_q    <= hw_n;
      if (bus.we && bus.addr == 2'd1) mask <= bus.wdata[N_SRC-1:0];
      if (bus.we && bus.addr == 2'd2) mode <= bus.wdata[N_SRC-1:0];
    end
  end

  always_comb begin
    hw_int             = '0;
    hw_int[N_SRC-1:0]  = hw_q;
  end

  assign busy = |insv;

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      2'd0:    bus.rdata[N_SRC-1:0] = pending;
      2'd1:    bus.rdata[N_SRC-1:0] = mask;
      2'd2:    bus.rdata[N_SRC-1:0] = mode;
      default: bus.rdata[N_SRC-1:0] = insv;
    endcase
  end
endmodule
